// File: rtl/exc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exc_ctrl_pkg
// Shared WiscSP13 definitions for the commit-point exception responder.
//   PC_W               : program counter width
//   CNT_W              : width of the flush window counter (FLUSH_CYCLES 1..7)
//   EXC_VECTOR_DEFAULT : SIIC handler entry point
//   state_e            : responder state (RUN / FLUSH / HALT)
// ---------------------------------------------------------------------------
package exc_ctrl_pkg;

   localparam int PC_W  = 16;
   localparam int CNT_W = 3;

   localparam logic [PC_W-1:0] EXC_VECTOR_DEFAULT = 16'h0002;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_e;

endpackage : exc_ctrl_pkg

// File: rtl/exc_ctrl_flush_timer.sv
// ---------------------------------------------------------------------------
// flush_timer
// Loadable down-counter that times the pipeline squash window after a
// redirect. The count freezes while the memory system stalls.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : load load_val_i (issued together with a redirect)
//   load_val_i  : window length in non-stalled cycles
//   freeze_i    : hold the count (mem_stall)
//   force_i     : hold flush high regardless of the count (halted)
//   busy_o      : count is non-zero
//   expire_o    : the current cycle is the last flush cycle
//   flush_o     : registered squash output
// ---------------------------------------------------------------------------
module flush_timer
   import exc_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             freeze_i,
   input  logic             force_i,
   output logic             busy_o,
   output logic             expire_o,
   output logic             flush_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_q, flush_d;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if ((cnt_q != '0) && !freeze_i) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      // flush is registered from the next count, so it rises in the same
      // cycle as the redirect pulse and drops right after the last count.
      flush_d = force_i || (cnt_d != '0);
   end

   // NOTE: sequential state uses non-blocking assignments only; the reset
   // branch is asynchronous so a mid-window reset clears flush immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         flush_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
      end
   end

   assign busy_o   = (cnt_q != '0);
   assign expire_o = (cnt_q == CNT_W'(1)) && !freeze_i;
   assign flush_o  = flush_q;

endmodule : flush_timer

// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// exc_ctrl
// Commit-point exception / RTI responder for the WiscSP13 pipeline. Acts on
// HALT, SIIC and RTI once they commit: saves/restores EPC, issues a one-cycle
// PC redirect, squashes younger instructions, and latches the halted state.
// Parameters:
//   EXC_VECTOR   : handler entry PC loaded on SIIC
//   FLUSH_CYCLES : non-stalled cycles flush stays high after a redirect (1..7)
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   commit_valid/halt/exception/rti, commit_pc_plus2 : committing instruction
//   mem_stall                     : nothing commits, flush window freezes
//   redirect, redirect_pc         : one-cycle PC redirect and its target
//   flush                         : squash stages younger than commit
//   epc                           : saved return PC
//   in_handler                    : inside an SIIC handler
//   halted, nested_err            : sticky terminal flags
// ---------------------------------------------------------------------------
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [PC_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
   parameter int unsigned     FLUSH_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            commit_valid,
   input  logic            commit_halt,
   input  logic            commit_exception,
   input  logic            commit_rti,
   input  logic [PC_W-1:0] commit_pc_plus2,
   input  logic            mem_stall,
   output logic            redirect,
   output logic [PC_W-1:0] redirect_pc,
   output logic            flush,
   output logic [PC_W-1:0] epc,
   output logic            in_handler,
   output logic            halted,
   output logic            nested_err
);

   state_e          state_q, state_d;
   logic            redirect_q, redirect_d;
   logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
   logic [PC_W-1:0] epc_q, epc_d;
   logic            in_handler_q, in_handler_d;
   logic            halted_q, halted_d;
   logic            nested_q, nested_d;
   logic            timer_load;
   logic            timer_busy;
   logic            timer_expire;
   logic            accept;

   // Commits only count in RUN and when memory is not stalling.
   assign accept = (state_q == RUN) && commit_valid && !mem_stall;

   always_comb begin
      state_d       = state_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      epc_d         = epc_q;
      in_handler_d  = in_handler_q;
      halted_d      = halted_q;
      nested_d      = nested_q;
      timer_load    = 1'b0;

      unique case (state_q)
         RUN: begin
            if (accept) begin
               // Priority: halt > exception > rti.
               if (commit_halt) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else if (commit_exception) begin
                  if (in_handler_q) begin
                     // SIIC inside the handler is unrecoverable; EPC keeps
                     // the original return address for post-mortem.
                     state_d  = HALT;
                     halted_d = 1'b1;
                     nested_d = 1'b1;
                  end else begin
                     state_d       = FLUSH;
                     epc_d         = commit_pc_plus2;
                     in_handler_d  = 1'b1;
                     redirect_d    = 1'b1;
                     redirect_pc_d = EXC_VECTOR;
                     timer_load    = 1'b1;
                  end
               end else if (commit_rti && in_handler_q) begin
                  state_d       = FLUSH;
                  in_handler_d  = 1'b0;
                  redirect_d    = 1'b1;
                  redirect_pc_d = epc_q;
                  timer_load    = 1'b1;
               end
               // RTI outside a handler falls through as a NOP.
            end
         end
         FLUSH: begin
            if (timer_expire || !timer_busy) begin
               state_d = RUN;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         epc_q         <= '0;
         in_handler_q  <= 1'b0;
         halted_q      <= 1'b0;
         nested_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         epc_q         <= epc_d;
         in_handler_q  <= in_handler_d;
         halted_q      <= halted_d;
         nested_q      <= nested_d;
      end
   end

   flush_timer u_flush_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (timer_load),
      .load_val_i (CNT_W'(FLUSH_CYCLES)),
      .freeze_i   (mem_stall),
      .force_i    (state_d == HALT),
      .busy_o     (timer_busy),
      .expire_o   (timer_expire),
      .flush_o    (flush)
   );

   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign epc         = epc_q;
   assign in_handler  = in_handler_q;
   assign halted      = halted_q;
   assign nested_err  = nested_q;

endmodule : exc_ctrl

// File: tb/tb_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_ctrl
// Self-checking bench for exc_ctrl: directed vector table, hand-written
// multi-cycle corner cases, and random stimulus against a behavioural model.
// ---------------------------------------------------------------------------
module tb_exc_ctrl;

   localparam logic [15:0] EXC_PC = 16'h0002;
   localparam int          FC     = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cv  = 1'b0;
   logic        ch  = 1'b0;
   logic        ce  = 1'b0;
   logic        cr  = 1'b0;
   logic        ms  = 1'b0;
   logic [15:0] pc  = '0;

   logic        redirect;
   logic [15:0] redirect_pc;
   logic        flush;
   logic [15:0] epc;
   logic        in_handler;
   logic        halted;
   logic        nested_err;

   int total = 0;
   int bad   = 0;

   exc_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .commit_valid     (cv),
      .commit_halt      (ch),
      .commit_exception (ce),
      .commit_rti       (cr),
      .commit_pc_plus2  (pc),
      .mem_stall        (ms),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .flush            (flush),
      .epc              (epc),
      .in_handler       (in_handler),
      .halted           (halted),
      .nested_err       (nested_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_red, input logic [15:0] e_rpc,
                             input logic e_fl, input logic [15:0] e_epc, input logic e_inh,
                             input logic e_hlt, input logic e_nst);
      check({tag, ".redirect"}, 16'(redirect), 16'(e_red));
      if (e_red) check({tag, ".redirect_pc"}, redirect_pc, e_rpc);
      check({tag, ".flush"}, 16'(flush), 16'(e_fl));
      check({tag, ".epc"}, epc, e_epc);
      check({tag, ".in_handler"}, 16'(in_handler), 16'(e_inh));
      check({tag, ".halted"}, 16'(halted), 16'(e_hlt));
      check({tag, ".nested_err"}, 16'(nested_err), 16'(e_nst));
   endtask

   task automatic drive(input logic v, input logic h, input logic e, input logic r,
                        input logic s, input logic [15:0] p);
      cv = v; ch = h; ce = e; cr = r; ms = s; pc = p;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 16'h0000);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // ---------------- behavioural model ----------------
   // flush_left = flush cycles still owed (each non-stalled cycle pays one).
   logic        m_red, m_inh, m_hlt, m_nst;
   logic [15:0] m_rpc, m_epc;
   int          m_flush_left;

   task automatic model_reset();
      m_red = 0; m_inh = 0; m_hlt = 0; m_nst = 0;
      m_rpc = '0; m_epc = '0; m_flush_left = 0;
   endtask

   task automatic model_step(input logic v, input logic h, input logic e, input logic r,
                             input logic s, input logic [15:0] p);
      m_red = 0;
      if (m_flush_left > 0) begin
         if (!s) m_flush_left--;
      end else if (!m_hlt && v && !s) begin
         if (h) begin
            m_hlt = 1;
         end else if (e) begin
            if (m_inh) begin
               m_nst = 1;
               m_hlt = 1;
            end else begin
               m_epc = p; m_inh = 1; m_red = 1; m_rpc = EXC_PC; m_flush_left = FC;
            end
         end else if (r && m_inh) begin
            m_rpc = m_epc; m_inh = 0; m_red = 1; m_flush_left = FC;
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        v, h, e, r, s;
      logic [15:0] pc;
      logic        red;
      logic [15:0] rpc;
      logic        fl;
      logic [15:0] epc;
      logic        inh, hlt, nst;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(input logic v, input logic h, input logic e, input logic r,
                               input logic s, input logic [15:0] p, input logic red,
                               input logic [15:0] rpc, input logic fl, input logic [15:0] ep,
                               input logic inh);
      vec_t t;
      t.v = v; t.h = h; t.e = e; t.r = r; t.s = s; t.pc = p;
      t.red = red; t.rpc = rpc; t.fl = fl; t.epc = ep; t.inh = inh;
      t.hlt = 0; t.nst = 0;
      return t;
   endfunction

   initial begin
      int flush_cnt;
      bit done;

      //             v  h  e  r  s  pc        red rpc       fl epc       inh
      tbl[0]  = mk(1, 0, 1, 0, 0, 16'h0124, 1, 16'h0002, 1, 16'h0124, 1); // SIIC
      tbl[1]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0124, 1);
      tbl[2]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0124, 1);
      tbl[3]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0124, 1);
      tbl[4]  = mk(1, 0, 0, 1, 0, 16'h0200, 1, 16'h0124, 1, 16'h0124, 0); // RTI
      tbl[5]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0124, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0124, 0);
      tbl[7]  = mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0124, 0);
      tbl[8]  = mk(1, 0, 0, 1, 0, 16'h0300, 0, 16'h0000, 0, 16'h0124, 0); // RTI nop
      tbl[9]  = mk(1, 0, 1, 0, 0, 16'h0400, 1, 16'h0002, 1, 16'h0400, 1); // SIIC
      tbl[10] = mk(1, 0, 1, 0, 0, 16'h0500, 0, 16'h0000, 1, 16'h0400, 1); // ignored in flush
      tbl[11] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0400, 1);
      tbl[12] = mk(0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0400, 1);
      tbl[13] = mk(1, 0, 0, 1, 1, 16'h0000, 0, 16'h0000, 0, 16'h0400, 1); // stalled RTI
      tbl[14] = mk(1, 0, 0, 1, 0, 16'h0000, 1, 16'h0400, 1, 16'h0400, 0); // RTI

      // ---- reset state ----
      do_reset();
      check_outs("reset", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
      check("reset.redirect_pc", redirect_pc, 16'h0000);

      // ---- table ----
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].v, tbl[i].h, tbl[i].e, tbl[i].r, tbl[i].s, tbl[i].pc);
         step();
         check_outs($sformatf("tbl%0d", i), tbl[i].red, tbl[i].rpc, tbl[i].fl,
                    tbl[i].epc, tbl[i].inh, tbl[i].hlt, tbl[i].nst);
      end

      // ---- RTI straight after reset is a NOP ----
      do_reset();
      drive(1, 0, 0, 1, 0, 16'h0777);
      step();
      check_outs("rti_nop", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);

      // ---- nested SIIC ----
      do_reset();
      drive(1, 0, 1, 0, 0, 16'h0124);
      step();
      drive(0, 0, 0, 0, 0, 16'h0000);
      for (int i = 0; i < FC; i++) step();
      check_outs("nest.pre", 0, 16'h0000, 0, 16'h0124, 1, 0, 0);
      drive(1, 0, 1, 0, 0, 16'h0200);
      step();
      check_outs("nest.hit", 0, 16'h0000, 1, 16'h0124, 1, 1, 1);
      drive(1, 0, 0, 1, 0, 16'h0300);
      for (int i = 0; i < 4; i++) begin
         step();
         check_outs($sformatf("nest.hold%0d", i), 0, 16'h0000, 1, 16'h0124, 1, 1, 1);
      end
      do_reset();
      check_outs("nest.rst", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);

      // ---- halt beats exception; later commits ignored ----
      drive(1, 1, 1, 0, 0, 16'h0124);
      step();
      check_outs("halt", 0, 16'h0000, 1, 16'h0000, 0, 1, 0);
      drive(1, 0, 1, 0, 0, 16'h5555);
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs($sformatf("halt.ign%0d", i), 0, 16'h0000, 1, 16'h0000, 0, 1, 0);
      end

      // ---- stall stretches the flush window to FC+2 ----
      do_reset();
      drive(1, 0, 1, 0, 0, 16'h0124);
      flush_cnt = 0;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         step();
         if (flush) flush_cnt++;
         else done = 1;
         drive(0, 0, 0, 0, (flush_cnt == 1 || flush_cnt == 2), 16'h0000);
      end
      check("stall.done", 16'(done), 16'h0001);
      check("stall.flush_len", 16'(flush_cnt), 16'(FC + 2));

      // ---- asynchronous reset on flush cycle 2 ----
      do_reset();
      drive(1, 0, 1, 0, 0, 16'h0124);
      step();
      drive(0, 0, 0, 0, 0, 16'h0000);
      step();
      check("arst.pre_flush", 16'(flush), 16'h0001);
      #2;
      rst = 1'b1;
      #1;
      check_outs("arst", 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
      check("arst.redirect_pc", redirect_pc, 16'h0000);
      step();
      rst = 1'b0;

      // ---- random against model ----
      do_reset();
      model_reset();
      begin
         int halt_age = 0;
         for (int n = 0; n < 3000; n++) begin
            logic v, h, e, r, s;
            logic [15:0] p;
            if (($urandom_range(0, 99) < 1) || (halt_age > 4)) begin
               do_reset();
               model_reset();
               halt_age = 0;
            end
            v = ($urandom_range(0, 99) < 60);
            h = ($urandom_range(0, 99) < 3);
            e = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 30);
            s = ($urandom_range(0, 99) < 20);
            p = 16'($urandom);
            drive(v, h, e, r, s, p);
            model_step(v, h, e, r, s, p);
            step();
            check_outs("rand", m_red, m_rpc, (m_hlt || (m_flush_left > 0)), m_epc,
                       m_inh, m_hlt, m_nst);
            if (m_hlt) halt_age++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_exc_ctrl
